// File: rtl/soi_sample_fifo_if.sv
// Read-side handshake between the SOI sampler FIFO and the host reader.
// The master drives valid/data and the slave drives ready.
interface soi_sample_fifo_if #(
    parameter int REC_W = 52
);
    logic             rd_valid;
    logic             rd_ready;
    logic [REC_W-1:0] rd_data;

    modport master (output rd_valid, output rd_data, input rd_ready);
    modport slave  (input rd_valid, input rd_data, output rd_ready);
endinterface

// File: rtl/soi_sample_fifo.sv
// Multi-channel SOI sampler.
// Enabled channels are captured either periodically or whenever they change.
// Each capture is timestamped and the record is pushed into a first-word-fall-through
// FIFO, which the host drains through a valid/ready handshake.
module soi_sample_fifo #(
    parameter int NUM_CH       = 4,
    parameter int CH_W         = 8,
    parameter int DEPTH        = 16,
    parameter int TS_W         = 16,
    parameter int STOP_ON_FULL = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*CH_W-1:0]   soi_in,
    input  logic [NUM_CH-1:0]        ch_en,
    input  logic                     mode,
    input  logic [15:0]              period,
    input  logic                     arm,
    input  logic                     disarm,
    soi_sample_fifo_if.master        rd,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_cnt,
    output logic                     running
);
    localparam int AW    = $clog2(DEPTH);
    localparam int VAL_W = NUM_CH * CH_W;
    localparam int REC_W = TS_W + NUM_CH + VAL_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_t;

    state_t             state, state_nxt;
    logic [TS_W-1:0]    ts;
    logic [15:0]        pcnt;
    logic [15:0]        per_eff;
    logic [VAL_W-1:0]   last;
    logic [VAL_W-1:0]   masked;
    logic [NUM_CH-1:0]  diff;
    logic [NUM_CH-1:0]  mask;
    logic [REC_W-1:0]   mem [DEPTH];
    logic [AW:0]        wptr, rptr;
    logic               full, empty, pop, push, drop;
    logic               per_hit, cap_evt, enter_run;

    // Per-channel masking and change detection against the last captured values
    always_comb begin
        masked = '0;
        diff   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            masked[i*CH_W +: CH_W] = ch_en[i] ? soi_in[i*CH_W +: CH_W] : '0;
            diff[i] = ch_en[i] && (soi_in[i*CH_W +: CH_W] != last[i*CH_W +: CH_W]);
        end
    end

    // Capture event decode and FIFO handshake qualifiers
    always_comb begin
        per_eff = (period == 16'd0) ? 16'd1 : period;
        // >= keeps the counter wrapping if period is lowered mid-run
        per_hit = (pcnt >= per_eff - 16'd1);
        cap_evt = (state == S_RUN) && (mode ? (|diff) : per_hit);
        mask    = mode ? diff : ch_en;
        empty   = (wptr == rptr);
        full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
        pop     = !empty && rd.rd_ready;
        // A pop in the same cycle frees the slot the new record lands in
        push    = cap_evt && (!full || pop);
        drop    = cap_evt && full && !pop;
    end

    // Next-state logic for the capture controller; disarm has priority over arm
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: if (!disarm && arm) state_nxt = S_RUN;
            S_RUN: begin
                if (disarm)                          state_nxt = S_IDLE;
                else if (STOP_ON_FULL != 0 && full)  state_nxt = S_STOP;
            end
            S_STOP: begin
                if (disarm)             state_nxt = S_IDLE;
                else if (arm && !full)  state_nxt = S_RUN;
            end
            default: state_nxt = S_IDLE;
        endcase
        enter_run = (state != S_RUN) && (state_nxt == S_RUN);
    end

    // Controller state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Free-running timestamp, period counter and last-sample registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ts   <= '0;
            pcnt <= '0;
            last <= '0;
        end else begin
            ts <= ts + 1'b1;
            if (enter_run)            pcnt <= '0;
            else if (state == S_RUN)  pcnt <= per_hit ? 16'd0 : pcnt + 16'd1;
            if (enter_run || cap_evt) last <= masked;
        end
    end

    // FIFO pointers, sticky overflow and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end

    // Record storage; contents are qualified by the pointers, so no reset
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= {ts, mask, masked};
    end

    // Fall-through read port and status outputs
    always_comb begin
        rd.rd_valid = !empty;
        rd.rd_data  = empty ? '0 : mem[rptr[AW-1:0]];
        level       = wptr - rptr;
        running     = (state == S_RUN);
    end
endmodule
